// File: rtl/cpu_mailbox_responder_pkg.sv
// Shared register offsets and bit positions for the CPU mailbox responder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cpu_mailbox_responder_pkg;

   // Register offsets within the 8-word window
   localparam logic [2:0] MBOX_STATUS   = 3'd0;
   localparam logic [2:0] MBOX_RX_DATA  = 3'd1;
   localparam logic [2:0] MBOX_RX_POP   = 3'd2;
   localparam logic [2:0] MBOX_TX_DATA  = 3'd3;
   localparam logic [2:0] MBOX_IRQ_MASK = 3'd4;
   localparam logic [2:0] MBOX_ERROR    = 3'd5;

   // STATUS register bit positions
   localparam int STAT_RX_NONEMPTY = 0;
   localparam int STAT_TX_FULL     = 1;
   localparam int STAT_TX_EMPTY    = 2;
   localparam int STAT_RX_CNT_LSB  = 8;
   localparam int STAT_TX_CNT_LSB  = 16;

   // ERROR register bit positions
   localparam int ERR_TX_OVERFLOW  = 0;
   localparam int ERR_RX_UNDERFLOW = 1;
   localparam int ERR_TX_PARTIAL   = 2;

   // IRQ_MASK / interrupt source bit positions
   localparam int IRQ_RX_NONEMPTY  = 0;
   localparam int IRQ_TX_EMPTY     = 1;
   localparam int IRQ_ERROR        = 2;

   // Full-word byte enable pattern required for a TX push
   localparam logic [3:0] WB_FULL_WORD = 4'hF;

endpackage

// File: rtl/cpu_mailbox_responder_mbox_fifo.sv
// Synchronous word FIFO with head-of-queue visibility and next-state empty flag.
// Latency: a pushed word is visible at head_o the cycle after the push edge.
// Backpressure: push when full and pop when empty are ignored; full is judged on pre-edge state.
module mbox_fifo
   import cpu_mailbox_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic                           push_i,
   input  logic [WIDTH-1:0]               push_dat_i,
   input  logic                           pop_i,
   output logic [WIDTH-1:0]               head_o,
   output logic [$clog2(DEPTH):0]         count_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic                           nxt_empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Qualify requests against pre-edge occupancy and derive next pointers/count
   always_comb begin
      do_push     = push_i && !full_o;
      do_pop      = pop_i && !empty_o;
      wr_ptr_d    = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d     = count_q + CW'(do_push) - CW'(do_pop);
      nxt_empty_o = (count_d == '0);
   end

   // Pointer and occupancy registers; reset discards any stored words
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless once count returns to zero
   always_ff @(posedge clock_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

endmodule

// File: rtl/cpu_mailbox_responder.sv
// Memory-mapped CPU mailbox bridging an RX (link->CPU) and TX (CPU->link) word FIFO.
// Latency: read data 1 cycle after address; irq reflects state after the causing edge.
// Backpressure: rx_ready drops when RX is full; tx_valid/tx_ready handshake drains TX.
module cpu_mailbox_responder
   import cpu_mailbox_responder_pkg::*;
#(
   parameter int unsigned                 MEMORY_BUS_WIDTH = 32,
   parameter int unsigned                 FIFO_DEPTH       = 8,
   parameter logic [MEMORY_BUS_WIDTH-3:0] BASE_WORD_ADDR   = '0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [MEMORY_BUS_WIDTH-3:0]   addr_out,
   input  logic [MEMORY_BUS_WIDTH-1:0]   data_out,
   input  logic [3:0]                    wb_out,
   output logic [MEMORY_BUS_WIDTH-1:0]   data_in,
   output logic                          irq,
   input  logic                          rx_valid,
   input  logic [MEMORY_BUS_WIDTH-1:0]   rx_data,
   output logic                          rx_ready,
   output logic                          tx_valid,
   output logic [MEMORY_BUS_WIDTH-1:0]   tx_data,
   input  logic                          tx_ready
);

   localparam int unsigned MBW = MEMORY_BUS_WIDTH;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

   logic           hit, wr_en;
   logic [2:0]     off;
   logic           rx_push, rx_pop, tx_push, tx_pop;
   logic [MBW-1:0] rx_head, tx_head;
   logic [CW-1:0]  rx_count, tx_count;
   logic           rx_full, rx_empty, rx_nxt_empty;
   logic           tx_full, tx_empty, tx_nxt_empty;
   logic [2:0]     err_set, err_clr, irq_src;
   logic [2:0]     irq_mask_q, irq_mask_d;
   logic [2:0]     error_q, error_d;
   logic [MBW-1:0] status, rd_dat;
   logic [MBW-1:0] data_in_q, data_in_d;
   logic           irq_q, irq_d;

   // Link-side handshakes are forced low while reset is held
   assign rx_ready = !reset && !rx_full;
   assign tx_valid = !reset && !tx_empty;
   assign tx_data  = tx_valid ? tx_head : '0;
   assign rx_push  = rx_valid && rx_ready;
   assign tx_pop   = tx_valid && tx_ready;
   assign data_in  = data_in_q;
   assign irq      = irq_q;

   mbox_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(MBW)) u_rx_fifo (
      .clock_i     (clock),
      .reset_i     (reset),
      .push_i      (rx_push),
      .push_dat_i  (rx_data),
      .pop_i       (rx_pop),
      .head_o      (rx_head),
      .count_o     (rx_count),
      .full_o      (rx_full),
      .empty_o     (rx_empty),
      .nxt_empty_o (rx_nxt_empty)
   );

   mbox_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(MBW)) u_tx_fifo (
      .clock_i     (clock),
      .reset_i     (reset),
      .push_i      (tx_push),
      .push_dat_i  (data_out),
      .pop_i       (tx_pop),
      .head_o      (tx_head),
      .count_o     (tx_count),
      .full_o      (tx_full),
      .empty_o     (tx_empty),
      .nxt_empty_o (tx_nxt_empty)
   );

   // Address decode and CPU write strobes into the FIFOs
   always_comb begin
      hit     = (addr_out[MBW-3:3] == BASE_WORD_ADDR[MBW-3:3]);
      off     = addr_out[2:0];
      wr_en   = hit && (wb_out != 4'h0);
      rx_pop  = wr_en && (off == MBOX_RX_POP);
      tx_push = wr_en && (off == MBOX_TX_DATA) && (wb_out == WB_FULL_WORD);
   end

   // Error capture and mask update; a newly raised error beats a same-cycle clear
   always_comb begin
      err_set                   = '0;
      err_set[ERR_TX_OVERFLOW]  = tx_push && tx_full;
      err_set[ERR_RX_UNDERFLOW] = rx_pop && rx_empty;
      err_set[ERR_TX_PARTIAL]   = wr_en && (off == MBOX_TX_DATA) && (wb_out != WB_FULL_WORD);
      err_clr = (wr_en && (off == MBOX_ERROR) && wb_out[0]) ? data_out[2:0] : 3'b000;
      error_d = (error_q & ~err_clr) | err_set;
      irq_mask_d = (wr_en && (off == MBOX_IRQ_MASK) && wb_out[0]) ? data_out[2:0] : irq_mask_q;
   end

   // Register read mux over pre-edge state; misses and write-only slots read zero
   always_comb begin
      status                            = '0;
      status[STAT_RX_NONEMPTY]          = !rx_empty;
      status[STAT_TX_FULL]              = tx_full;
      status[STAT_TX_EMPTY]             = tx_empty;
      status[STAT_RX_CNT_LSB +: 8]      = 8'(rx_count);
      status[STAT_TX_CNT_LSB +: 8]      = 8'(tx_count);
      case (off)
         MBOX_STATUS:   rd_dat = status;
         MBOX_RX_DATA:  rd_dat = rx_head;
         MBOX_IRQ_MASK: rd_dat = MBW'(irq_mask_q);
         MBOX_ERROR:    rd_dat = MBW'(error_q);
         default:       rd_dat = '0;
      endcase
      data_in_d = hit ? rd_dat : '0;
   end

   // Interrupt level computed from the state that will exist after this edge
   always_comb begin
      irq_src                  = '0;
      irq_src[IRQ_RX_NONEMPTY] = !rx_nxt_empty;
      irq_src[IRQ_TX_EMPTY]    = tx_nxt_empty;
      irq_src[IRQ_ERROR]       = |error_d;
      irq_d                    = |(irq_mask_d & irq_src);
   end

   // Control/status registers, read-data flop and interrupt flop
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_mask_q <= '0;
         error_q    <= '0;
         data_in_q  <= '0;
         irq_q      <= 1'b0;
      end else begin
         irq_mask_q <= irq_mask_d;
         error_q    <= error_d;
         data_in_q  <= data_in_d;
         irq_q      <= irq_d;
      end
   end

endmodule
